// File: rtl/fir_i2s_tx.sv
// fir_i2s_tx: rounds/saturates FIR results to 16-bit samples and sends them as a mono I2S master stream.
module fir_i2s_tx #(
  parameter int RESULT_W  = 39,
  parameter int SAMPLE_W  = 16,
  parameter int FRAC_BITS = 15,
  parameter int SCK_HALF  = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic [RESULT_W-1:0] i_result,
  output logic                o_sck,
  output logic                o_ws,
  output logic                o_sd,
  output logic                o_clip,
  output logic                o_dropped
);
  localparam int CW = $clog2(SCK_HALF);
  localparam int FW = 2 * SAMPLE_W;
  localparam int PW = $clog2(FW);
  localparam logic signed [RESULT_W:0] SAT_MAX = (RESULT_W+1)'(2 ** (SAMPLE_W - 1) - 1);
  localparam logic signed [RESULT_W:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [RESULT_W:0] HALF    = (RESULT_W+1)'(2 ** (FRAC_BITS - 1));
  logic [CW-1:0]       cnt_q;
  logic                sck_q, ws_q, sd_q, clip_q, drop_q, pend_full_q;
  logic [PW-1:0]       p_q, p_d;
  logic [SAMPLE_W-1:0] pend_q, last_q, sample_d, src;
  logic [FW-1:0]       sh_q;
  logic signed [RESULT_W:0] t, s;
  logic                sat_hi, sat_lo, tick, fall, load, ws_d;
  always_comb begin
    t        = $signed({i_result[RESULT_W-1], i_result}) + HALF;
    s        = t >>> FRAC_BITS;
    sat_hi   = s > SAT_MAX;
    sat_lo   = s < SAT_MIN;
    sample_d = sat_hi ? SAT_MAX[SAMPLE_W-1:0] : sat_lo ? SAT_MIN[SAMPLE_W-1:0] : s[SAMPLE_W-1:0];
    tick     = cnt_q == CW'(SCK_HALF - 1);
    fall     = tick & sck_q;
    load     = fall & (p_q == '1);
    p_d      = p_q + PW'(1);
    ws_d     = (p_d >= PW'(SAMPLE_W - 1)) && (p_d <= PW'(FW - 2));
    src      = pend_full_q ? pend_q : last_q;
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      cnt_q       <= '0;
      sck_q       <= 1'b0;
      p_q         <= '1;
      ws_q        <= 1'b0;
      sd_q        <= 1'b0;
      sh_q        <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      last_q      <= '0;
      clip_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
      if (tick) sck_q <= ~sck_q;
      // data and word select move only on the bit-clock falling edge
      if (fall) begin
        p_q  <= p_d;
        ws_q <= ws_d;
        sd_q <= load ? src[SAMPLE_W-1] : sh_q[FW-1];
        sh_q <= load ? {src[SAMPLE_W-2:0], src, 1'b0} : {sh_q[FW-2:0], 1'b0};
      end
      if (load) last_q <= src;
      if (i_valid) pend_q <= sample_d;
      pend_full_q <= i_valid | (pend_full_q & ~load);
      clip_q      <= i_valid & (sat_hi | sat_lo);
      drop_q      <= i_valid & pend_full_q & ~load;
    end
  end
  assign o_sck     = sck_q;
  assign o_ws      = ws_q;
  assign o_sd      = sd_q;
  assign o_clip    = clip_q;
  assign o_dropped = drop_q;
endmodule

// File: tb/tb_fir_i2s_tx.sv
// tb_fir_i2s_tx: directed vectors for fir_i2s_tx; an I2S receiver rebuilds each frame from o_sck/o_ws/o_sd.
module tb_fir_i2s_tx;
  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_valid = 1'b0;
  logic [38:0] i_result = '0;
  logic        o_sck, o_ws, o_sd, o_clip, o_dropped;
  int          errs = 0, checks = 0;
  int          p31_cnt = 0, n_clip = 0, n_drop = 0;
  logic [4:0]  mon_p = 5'd30;
  logic        prev_sck = 1'b0, have = 1'b0, last_ok = 1'b0;
  logic [31:0] word = '0, wsw = '0, last_ws = '0;
  logic [15:0] last_l = '0, last_r = '0;
  logic        sck_seen [1:8];
  int          c0, d0;

  fir_i2s_tx dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_result(i_result),
    .o_sck(o_sck), .o_ws(o_ws), .o_sd(o_sd), .o_clip(o_clip), .o_dropped(o_dropped)
  );

  always #5 clk = ~clk;

  // receiver: samples o_sd/o_ws on each o_sck rise; first rise after reset is bit 31
  initial forever begin
    @(posedge clk);
    #2;
    if (!i_reset) begin
      mon_p = 5'd30; have = 1'b0; last_ok = 1'b0; prev_sck = 1'b0;
    end else begin
      if (o_clip) n_clip++;
      if (o_dropped) n_drop++;
      if (o_sck && !prev_sck) begin
        mon_p = mon_p + 5'd1;
        word[5'd31 - mon_p] = o_sd;
        wsw[mon_p] = o_ws;
        if (mon_p == 5'd0) have = 1'b1;
        if (mon_p == 5'd31) begin
          if (have) begin
            last_l = word[31:16]; last_r = word[15:0]; last_ws = wsw; last_ok = 1'b1;
          end
          p31_cnt++;
        end
      end
      prev_sck = o_sck;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_evt(input string tag);
    int s = p31_cnt;
    for (int n = 0; n < 3000 && p31_cnt == s; n++) @(negedge clk);
    if (p31_cnt == s) check({tag, "_timeout"}, 32'(p31_cnt), 32'(s + 1));
  endtask

  task automatic check_frame(input string tag, input logic [15:0] exp);
    wait_evt(tag);
    check({tag, "_ok"}, 32'(last_ok), 32'd1);
    check({tag, "_L"}, 32'(last_l), 32'(exp));
    check({tag, "_R"}, 32'(last_r), 32'(exp));
    check({tag, "_ws"}, last_ws, 32'h7FFF8000);
  endtask

  task automatic pulse(input longint v);
    i_valid = 1'b1;
    i_result = v[38:0];
    @(negedge clk);
    i_valid = 1'b0;
    i_result = '0;
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check("rst_out", 32'({o_sck, o_ws, o_sd, o_clip, o_dropped}), 32'd0);
    i_reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      sck_seen[k] = o_sck;
    end
    check("sck_c3", 32'(sck_seen[3]), 32'd0);
    check("sck_c4", 32'(sck_seen[4]), 32'd1);
    check("sck_c7", 32'(sck_seen[7]), 32'd1);
    check("sck_c8", 32'(sck_seen[8]), 32'd0);
    check_frame("first", 16'h0000);

    c0 = n_clip; d0 = n_drop;
    pulse(1234 * 32768);
    check_frame("basic", 16'h04D2);
    check("basic_clip", 32'(n_clip - c0), 32'd0);
    check("basic_drop", 32'(n_drop - d0), 32'd0);
    for (int i = 0; i < 3; i++) check_frame("hold", 16'h04D2);

    pulse(5 * 32768 + 16384);
    check_frame("rnd_up", 16'h0006);
    pulse(5 * 32768 + 16383);
    check_frame("rnd_dn", 16'h0005);
    pulse(-(5 * 32768 + 16384));
    check_frame("rnd_neg", 16'hFFFB);

    c0 = n_clip;
    pulse(longint'(1) << 37);
    check_frame("sat_hi", 16'h7FFF);
    check("sat_hi_clip", 32'(n_clip - c0), 32'd1);
    c0 = n_clip;
    pulse(-(longint'(1) << 38));
    check_frame("sat_lo", 16'h8000);
    check("sat_lo_clip", 32'(n_clip - c0), 32'd1);
    c0 = n_clip;
    pulse(32767 * 32768);
    check_frame("max", 16'h7FFF);
    check("max_clip", 32'(n_clip - c0), 32'd0);

    d0 = n_drop;
    pulse(100 * 32768);
    pulse(200 * 32768);
    check_frame("ovw", 16'd200);
    check("ovw_drop", 32'(n_drop - d0), 32'd1);

    d0 = n_drop;
    repeat (3) @(negedge clk);
    pulse(300 * 32768);
    check_frame("coll_old", 16'd200);
    check_frame("coll_new", 16'd300);
    check("coll_drop", 32'(n_drop - d0), 32'd0);

    for (int n = 0; n < 3000 && mon_p != 5'd20; n++) @(negedge clk);
    check("p20_ws", 32'(o_ws), 32'd1);
    i_reset = 1'b0;
    @(negedge clk);
    check("mid_rst_out", 32'({o_sck, o_ws, o_sd, o_clip, o_dropped}), 32'd0);
    repeat (2) @(negedge clk);
    i_reset = 1'b1;
    wait_evt("rst2");
    check_frame("post_rst", 16'h0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
